// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the PC sequencer.
//   PC_INC               : sequential instruction stride in bytes
//   DEFAULT_RESET_VECTOR : PC value loaded by reset unless overridden
//   pc_sel_e             : next-PC source, listed highest priority first
package pc_sequencer_pkg;

  localparam int PC_INC               = 4;
  localparam int DEFAULT_RESET_VECTOR = 0;

  typedef enum logic [2:0] {
    SEL_RAS,
    SEL_REG,
    SEL_JUMP,
    SEL_BRANCH,
    SEL_SEQ
  } pc_sel_e;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack.
// Ports:
//   clk, rst        : clock, synchronous active-high reset (pointer/count/flag only)
//   push, pop       : stack operations; both together replace the top entry
//   push_data       : address written by a push
//   top             : most recently pushed entry (undefined while empty)
//   empty, full     : occupancy status
//   overflow        : sticky, set when a push overwrote the oldest entry
module pc_ras #(
  parameter int ADDR_W    = 16,
  parameter int RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_data,
  output logic [ADDR_W-1:0] top,
  output logic              empty,
  output logic              full,
  output logic              overflow
);

  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(RAS_DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(RAS_DEPTH);

  logic [ADDR_W-1:0] entries [RAS_DEPTH];
  logic [PTR_W-1:0]  ptr;       // next slot to write
  logic [PTR_W-1:0]  top_idx;   // slot holding the newest entry
  logic [PTR_W-1:0]  ptr_inc;
  logic [CNT_W-1:0]  count;
  logic              replace;

  assign top_idx = (ptr == '0) ? LAST_IDX : ptr - PTR_W'(1);
  assign ptr_inc = (ptr == LAST_IDX) ? '0 : ptr + PTR_W'(1);
  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign top     = entries[top_idx];
  // A pop with nothing to pop degenerates to a plain push.
  assign replace = push && pop && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr      <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (replace) begin
      ptr      <= ptr;
      count    <= count;
    end else if (push) begin
      ptr <= ptr_inc;
      // When full the write lands on the oldest slot, so depth stays capped.
      if (full) overflow <= 1'b1;
      else      count    <= count + CNT_W'(1);
    end else if (pop && !empty) begin
      ptr   <= top_idx;
      count <= count - CNT_W'(1);
    end
  end

  // Entry storage carries no reset; stale contents are unreachable once count is 0.
  always_ff @(posedge clk) begin
    if (replace)   entries[top_idx] <= push_data;
    else if (push) entries[ptr]     <= push_data;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer with jump, register jump, branch and a
// return-address stack for call/return prediction.
// Ports:
//   clk, rst        : clock, synchronous active-high reset (overrides stall)
//   stall           : hold all state
//   jump            : jump instruction; jump_from_reg selects jr, link selects jal
//   ret             : register jump is a return (pops the stack)
//   branch, zero    : conditional branch taken when zero is set
//   branch_offset   : signed word offset for branches
//   jump_offset     : absolute word index for direct jumps
//   read_data1      : rs register value for register jumps
//   pc              : current instruction address
//   link_addr       : pc+4, combinational
//   ras_overflow    : sticky stack overflow flag
//   ras_underflow   : one-cycle pulse after a return found the stack empty
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int                ADDR_W       = 16,
  parameter int                RAS_DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(DEFAULT_RESET_VECTOR)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              jump,
  input  logic              jump_from_reg,
  input  logic              link,
  input  logic              ret,
  input  logic              branch,
  input  logic              zero,
  input  logic [15:0]       branch_offset,
  input  logic [25:0]       jump_offset,
  input  logic [ADDR_W-1:0] read_data1,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] link_addr,
  output logic              ras_overflow,
  output logic              ras_underflow
);

  pc_sel_e                  sel;
  logic [ADDR_W-1:0]        next_pc;
  logic [ADDR_W-1:0]        jump_tgt;
  logic [ADDR_W-1:0]        branch_tgt;
  logic signed [ADDR_W-1:0] branch_disp;
  logic [ADDR_W-1:0]        ras_top;
  logic                     ras_empty;
  logic                     ras_full;
  logic                     ras_push;
  logic                     ras_pop;
  logic                     reg_jump;
  logic                     underflow_hit;

  assign link_addr   = pc + ADDR_W'(PC_INC);
  assign jump_tgt    = ADDR_W'({jump_offset, 2'b00});
  assign branch_disp = ADDR_W'($signed({branch_offset, 2'b00}));
  assign branch_tgt  = link_addr + branch_disp;
  assign reg_jump    = jump && jump_from_reg;

  always_comb begin
    sel = SEL_SEQ;
    if (reg_jump && ret && !ras_empty) sel = SEL_RAS;
    else if (reg_jump)                 sel = SEL_REG;
    else if (jump)                     sel = SEL_JUMP;
    else if (branch && zero)           sel = SEL_BRANCH;
  end

  always_comb begin
    next_pc = link_addr;
    case (sel)
      SEL_RAS:    next_pc = ras_top;
      SEL_REG:    next_pc = read_data1;
      SEL_JUMP:   next_pc = jump_tgt;
      SEL_BRANCH: next_pc = branch_tgt;
      default:    next_pc = link_addr;
    endcase
  end

  // Stack operations are squashed by stall and by reset on the same edge.
  assign ras_push      = !rst && !stall && jump && link;
  assign ras_pop       = !rst && !stall && (sel == SEL_RAS);
  assign underflow_hit = reg_jump && ret && ras_empty;

  pc_ras #(
    .ADDR_W    (ADDR_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (link_addr),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (ras_full),
    .overflow  (ras_overflow)
  );

  // PC register stage
  always_ff @(posedge clk) begin
    if (rst) begin
      pc            <= RESET_VECTOR;
      ras_underflow <= 1'b0;
    end else if (stall) begin
      pc            <= pc;
      ras_underflow <= 1'b0;
    end else begin
      pc            <= next_pc;
      ras_underflow <= underflow_hit;
    end
  end

  logic unused_full;
  assign unused_full = ras_full;

endmodule
